// File: rtl/pll_pkg.sv
// Shared types and default widths for the digital PLL phase path.
package pll_pkg;

  // Phase detector state encoding.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REF_LEAD = 2'd1,
    FB_LEAD  = 2'd2
  } pfd_state_e;

  // Default phase counter magnitude width and the signed error width it implies.
  localparam int unsigned CNT_WIDTH_DEF = 16;
  localparam int unsigned ERR_WIDTH_DEF = CNT_WIDTH_DEF + 1;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous clock-like input plus a rising-edge strobe.
module sync_edge_detect (
  input  logic clk_in,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_c_o
);

  logic s1_q, s2_q, s3_q;

  // Synchronizer chain; the third stage only exists to detect the edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Rising edges only; falling edges carry no phase information here.
  assign rise_c_o = s2_q & ~s3_q;

endmodule

// File: rtl/digital_pfd.sv
// Sampled phase-frequency detector: measures ref/fb edge offset in clk_in cycles and tracks lock.
module digital_pfd
  import pll_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int unsigned LOCK_TOL   = 2,
  parameter int unsigned LOCK_COUNT = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 ref_in,
  input  logic                 fb_in,
  output logic                 up,
  output logic                 dn,
  output logic [CNT_WIDTH:0]   phase_err,
  output logic                 err_valid,
  output logic                 cycle_slip,
  output logic                 locked
);

  localparam int unsigned ERR_W = CNT_WIDTH + 1;
  localparam int unsigned LCW   = $clog2(LOCK_COUNT + 1);

  logic rise_ref, rise_fb;

  sync_edge_detect u_sync_ref (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .async_i  (ref_in),
    .rise_c_o (rise_ref)
  );

  sync_edge_detect u_sync_fb (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .async_i  (fb_in),
    .rise_c_o (rise_fb)
  );

  pfd_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [ERR_W-1:0]     err_q, err_d;
  logic                 ev_q, ev_d;
  logic                 slip_q, slip_d;
  logic                 up_q, up_d;
  logic                 dn_q, dn_d;
  logic [LCW-1:0]       lock_cnt_q, lock_nxt;
  logic                 locked_q;
  logic [ERR_W-1:0]     err_mag;
  logic                 in_tol;

  // Saturating cycle counter increment.
  assign cnt_inc = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  // Next-state and measurement decode; up/dn follow the state being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ev_d    = 1'b0;
    slip_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise_ref && rise_fb) begin
          ev_d  = 1'b1;
          err_d = '0;
        end else if (rise_ref) begin
          state_d = REF_LEAD;
          cnt_d   = CNT_WIDTH'(1);
        end else if (rise_fb) begin
          state_d = FB_LEAD;
          cnt_d   = CNT_WIDTH'(1);
        end
      end
      REF_LEAD: begin
        if (rise_fb) begin
          ev_d    = 1'b1;
          err_d   = ERR_W'(cnt_q);
          state_d = IDLE;
        end else if (rise_ref) begin
          slip_d = 1'b1;
          cnt_d  = CNT_WIDTH'(1);
        end else begin
          cnt_d = cnt_inc;
        end
      end
      FB_LEAD: begin
        if (rise_ref) begin
          ev_d    = 1'b1;
          err_d   = ERR_W'(0) - ERR_W'(cnt_q);
          state_d = IDLE;
        end else if (rise_fb) begin
          slip_d = 1'b1;
          cnt_d  = CNT_WIDTH'(1);
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
    up_d = (state_d == REF_LEAD);
    dn_d = (state_d == FB_LEAD);
  end

  // Detector state and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      ev_q    <= 1'b0;
      slip_q  <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ev_q    <= ev_d;
      slip_q  <= slip_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
    end
  end

  // Error magnitude never reaches the most negative code, so negation cannot overflow.
  assign err_mag  = err_q[ERR_W-1] ? (ERR_W'(0) - err_q) : err_q;
  assign in_tol   = (err_mag <= ERR_W'(LOCK_TOL));
  assign lock_nxt = (lock_cnt_q >= LCW'(LOCK_COUNT)) ? lock_cnt_q : lock_cnt_q + LCW'(1);

  // Lock qualifier driven by the registered comparison results.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else if (slip_q || (ev_q && !in_tol)) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else if (ev_q) begin
      lock_cnt_q <= lock_nxt;
      locked_q   <= (lock_nxt == LCW'(LOCK_COUNT));
    end
  end

  assign up         = up_q;
  assign dn         = dn_q;
  assign phase_err  = err_q;
  assign err_valid  = ev_q;
  assign cycle_slip = slip_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_digital_pfd.sv
// Directed bench for the sampled phase-frequency detector.
module tb_digital_pfd;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic        ref_in = 1'b0;
  logic        fb_in  = 1'b0;

  logic        up, dn, err_valid, cycle_slip, locked;
  logic [16:0] phase_err;
  logic        up4, dn4, err_valid4, cycle_slip4, locked4;
  logic [4:0]  phase_err4;

  always #5 clk_in = ~clk_in;

  digital_pfd dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .ref_in     (ref_in),
    .fb_in      (fb_in),
    .up         (up),
    .dn         (dn),
    .phase_err  (phase_err),
    .err_valid  (err_valid),
    .cycle_slip (cycle_slip),
    .locked     (locked)
  );

  digital_pfd #(.CNT_WIDTH(4)) dut4 (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .ref_in     (ref_in),
    .fb_in      (fb_in),
    .up         (up4),
    .dn         (dn4),
    .phase_err  (phase_err4),
    .err_valid  (err_valid4),
    .cycle_slip (cycle_slip4),
    .locked     (locked4)
  );

  int errors = 0;
  int checks = 0;

  int cyc, n_ev, n_slip, last_err, last_err4, up_cyc, dn_cyc, both_hi;
  int ev_t, lk_rise_t, lk_fall_t;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit active(input int t, input int at);
    return (at >= 0) && (t >= at) && (t < at + 3);
  endfunction

  // Drives ref rises at ra (and rb if >=0) and an fb rise at fa, observing outputs each cycle.
  task automatic run_window(input int ra, input int rb, input int fa, input int len);
    logic prev_lk;
    n_ev = 0; n_slip = 0; last_err = 9999; last_err4 = 9999;
    up_cyc = 0; dn_cyc = 0; both_hi = 0;
    ev_t = -100; lk_rise_t = -100; lk_fall_t = -100;
    prev_lk = locked;
    for (int t = 0; t < len; t++) begin
      @(negedge clk_in);
      cyc++;
      if (up) up_cyc++;
      if (dn) dn_cyc++;
      if (up && dn) both_hi++;
      if (cycle_slip) n_slip++;
      if (err_valid) begin
        n_ev++;
        ev_t = cyc;
        last_err = int'($signed(phase_err));
      end
      if (err_valid4) last_err4 = int'($signed(phase_err4));
      if (locked && !prev_lk) lk_rise_t = cyc;
      if (!locked && prev_lk) lk_fall_t = cyc;
      prev_lk = locked;
      ref_in = active(t, ra) || active(t, rb);
      fb_in  = active(t, fa);
    end
    ref_in = 1'b0;
    fb_in  = 1'b0;
    repeat (4) @(negedge clk_in);
  endtask

  initial begin
    bit seen_up;
    cyc = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_up", int'(up), 0);
    check("rst_dn", int'(dn), 0);
    check("rst_phase_err", int'(phase_err), 0);
    check("rst_err_valid", int'(err_valid), 0);
    check("rst_cycle_slip", int'(cycle_slip), 0);
    check("rst_locked", int'(locked), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_in);
    check("post_rst_up", int'(up), 0);

    // ref leads by 5
    run_window(0, -1, 5, 15);
    check("t1_ev_count", n_ev, 1);
    check("t1_phase_err", last_err, 5);
    check("t1_up_cycles", up_cyc, 5);
    check("t1_dn_cycles", dn_cyc, 0);

    // fb leads by 3
    run_window(3, -1, 0, 13);
    check("t2_ev_count", n_ev, 1);
    check("t2_phase_err", last_err, -3);
    check("t2_dn_cycles", dn_cyc, 3);
    check("t2_up_cycles", up_cyc, 0);

    // simultaneous edges
    run_window(0, -1, 0, 10);
    check("t3_ev_count", n_ev, 1);
    check("t3_phase_err", last_err, 0);
    check("t3_up_cycles", up_cyc, 0);
    check("t3_dn_cycles", dn_cyc, 0);

    // double ref edge then fb 4 cycles after the second
    run_window(0, 20, 24, 34);
    check("t4_slip_count", n_slip, 1);
    check("t4_ev_count", n_ev, 1);
    check("t4_phase_err", last_err, 4);
    check("t4_locked", int'(locked), 0);
    check("t4_never_both", both_hi, 0);

    // saturation on the narrow counter; wide counter measures fully
    run_window(0, -1, 40, 50);
    check("t5_phase_err_w4_sat", last_err4, 15);
    check("t5_phase_err_w16", last_err, 40);
    check("t5_up_cycles", up_cyc, 40);

    // lock acquisition with eight in-tolerance comparisons
    for (int i = 0; i < 7; i++) run_window(0, -1, 1, 10);
    check("t6_phase_err_p1", last_err, 1);
    check("t6_locked_after7", int'(locked), 0);
    run_window(0, -1, 1, 10);
    check("t6_locked_after8", int'(locked), 1);
    check("t6_lock_delay", lk_rise_t - ev_t, 1);

    // out-of-tolerance comparison drops lock
    run_window(0, -1, 3, 12);
    check("t6_phase_err_p3", last_err, 3);
    check("t6_unlocked", int'(locked), 0);
    check("t6_unlock_delay", lk_fall_t - ev_t, 1);

    // reset in the middle of a ref-lead measurement
    seen_up = 1'b0;
    @(negedge clk_in);
    ref_in = 1'b1;
    for (int i = 0; i < 10 && !seen_up; i++) begin
      @(negedge clk_in);
      if (up) seen_up = 1'b1;
    end
    check("t6_up_before_rst", int'(seen_up), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_up", int'(up), 0);
    check("t6_rst_dn", int'(dn), 0);
    check("t6_rst_phase_err", int'(phase_err), 0);
    check("t6_rst_err_valid", int'(err_valid), 0);
    check("t6_rst_cycle_slip", int'(cycle_slip), 0);
    check("t6_rst_locked", int'(locked), 0);
    ref_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);

    // first comparison after reset starts fresh
    run_window(4, -1, 0, 14);
    check("t7_ev_count", n_ev, 1);
    check("t7_phase_err", last_err, -4);
    check("t7_up_cycles", up_cyc, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
